// File: rtl/attn_wrap_pkg.sv
// attn_wrap_pkg
// Shared definitions for the attention stream wrapper:
//   - AXI-lite register byte offsets
//   - CTRL command bit positions and STATUS bit positions
//   - wrapper FSM state encoding
// No ports; imported by attn_stream_wrap and attn_lane_pack.
package attn_wrap_pkg;

  localparam logic [11:0] ADDR_CTRL      = 12'h000;
  localparam logic [11:0] ADDR_HEAD      = 12'h004;
  localparam logic [11:0] ADDR_DIM       = 12'h008;
  localparam logic [11:0] ADDR_LENGTH    = 12'h00C;
  localparam logic [11:0] ADDR_OUT_TOTAL = 12'h010;
  localparam logic [11:0] ADDR_STATUS    = 12'h014;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_ERR    = 2;
  localparam int STAT_IRQ_EN = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/attn_lane_pack.sv
// attn_lane_pack
// Collects ELEM_W-wide core results into a LANES-wide output beat, lane 0
// first (LSBs). A beat is presented when all lanes are filled or when the
// element flagged in_last arrives; unfilled lanes of such a beat are zero.
// The beat is held until out_rdy, and no new element is accepted meanwhile.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           discard the partial/held beat
//   enable          accepting elements is allowed (wrapper in RUN)
//   in_vld/in_dat/in_last/in_rdy   element input handshake
//   out_vld/out_dat/out_last/out_rdy   beat output handshake
module attn_lane_pack
  import attn_wrap_pkg::*;
#(
  parameter int ELEM_W = 16,
  parameter int LANES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    enable,
  input  logic                    in_vld,
  input  logic [ELEM_W-1:0]       in_dat,
  input  logic                    in_last,
  output logic                    in_rdy,
  output logic                    out_vld,
  output logic [LANES*ELEM_W-1:0] out_dat,
  output logic                    out_last,
  input  logic                    out_rdy
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0][ELEM_W-1:0] lanes_q;
  logic [IW-1:0]                fill_q;

  assign in_rdy  = enable && !out_vld;
  assign out_dat = lanes_q;

  // Lanes are zeroed whenever a beat leaves, so a short final beat is
  // automatically zero-padded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q  <= '0;
      fill_q   <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else if (flush || (out_vld && out_rdy)) begin
      lanes_q  <= '0;
      fill_q   <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else if (in_vld && in_rdy) begin
      lanes_q[fill_q] <= in_dat;
      if (in_last || (fill_q == IW'(LANES - 1))) begin
        out_vld  <= 1'b1;
        out_last <= in_last;
        fill_q   <= '0;
      end else begin
        fill_q <= fill_q + IW'(1);
      end
    end
  end

endmodule

// File: rtl/attn_stream_wrap.sv
// attn_stream_wrap
// AXI-lite + AXI-stream wrapper around an element-serial attention core.
// Input stream beats are split into LANES elements for the core; core results
// are repacked into output beats (attn_lane_pack). A job runs until OUT_TOTAL
// results have been taken from the core and the final beat has left.
// Ports:
//   axis_clk, axis_rst                     clock, async active-high reset
//   aw*/w*, ar*/r*                         AXI-lite register access
//   ss_*                                   input stream (LANES packed elements)
//   sm_*                                   output stream, sm_tlast on final beat
//   core_cfg                               {head, dim, length} to the core
//   core_din_*, core_dout_*                element handshakes with the core
//   low__pri_irq                           job-done pulse
// Build option: define ATTN_WRAP_IRQ_EN to enable the job-done interrupt and
// report STATUS.irq_en = 1; otherwise low__pri_irq is tied low.
module attn_stream_wrap
  import attn_wrap_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pELEM_WIDTH = 16
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [11:0]            awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [11:0]            araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  output logic [16:0]            core_cfg,
  output logic [pELEM_WIDTH-1:0] core_din_dat,
  output logic                   core_din_vld,
  input  logic                   core_din_rdy,
  input  logic [pELEM_WIDTH-1:0] core_dout_dat,
  input  logic                   core_dout_vld,
  output logic                   core_dout_rdy,
  output logic                   low__pri_irq
);

  localparam int LANES = pDATA_WIDTH / pELEM_WIDTH;
  localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;
`ifdef ATTN_WRAP_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  state_t state_q, state_d;

  logic [3:0]  head_q;
  logic [6:0]  dim_q;
  logic [5:0]  length_q;
  logic [15:0] out_total_q;
  logic [15:0] out_cnt_q;
  logic        done_q, err_q, busy;
  logic        wr_fire, start_req, clear_req, start_go, cfg_wr, set_done;
  logic        take, take_last, pack_en, pack_flush;
  logic [3:0]  status;
  logic [pDATA_WIDTH-1:0] rd_mux;

  logic [LANES-1:0][pELEM_WIDTH-1:0] din_lanes_q;
  logic [IW-1:0]                     lane_idx_q;
  logic                              din_full_q;

  logic unused_wdata;
  assign unused_wdata = ^wdata[pDATA_WIDTH-1:16];

  // Both AXI-lite ready signals are combinational so a write completes in
  // the very cycle address and data are both present.
  assign busy      = (state_q != ST_IDLE);
  assign wr_fire   = awvalid && wvalid && !axis_rst;
  assign awready   = wr_fire;
  assign wready    = wr_fire;
  assign arready   = arvalid && !rvalid && !axis_rst;

  // Clear wins over start when both bits are written together.
  assign start_req = wr_fire && (awaddr == ADDR_CTRL) && wdata[CTRL_START_BIT]
                     && !wdata[CTRL_CLEAR_BIT];
  assign clear_req = wr_fire && (awaddr == ADDR_CTRL) && wdata[CTRL_CLEAR_BIT];
  assign start_go  = start_req && (state_q == ST_IDLE);
  assign cfg_wr    = wr_fire && ((awaddr == ADDR_HEAD) || (awaddr == ADDR_DIM) ||
                     (awaddr == ADDR_LENGTH) || (awaddr == ADDR_OUT_TOTAL));

  assign core_cfg   = {head_q, dim_q, length_q};
  assign take       = core_dout_vld && core_dout_rdy;
  assign take_last  = ((out_cnt_q + 16'd1) == out_total_q);
  assign pack_en    = (state_q == ST_RUN) && (out_total_q != 16'd0);
  assign pack_flush = clear_req || start_go;

  // State register.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; set_done marks the edge on which a job completes.
  always_comb begin
    state_d  = state_q;
    set_done = 1'b0;
    if (clear_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_req) state_d = ST_RUN;
        ST_RUN: begin
          if (out_total_q == 16'd0) begin
            state_d  = ST_IDLE;
            set_done = 1'b1;
          end else if (take && take_last) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (sm_tvalid && sm_tready && sm_tlast) begin
            state_d  = ST_IDLE;
            set_done = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Configuration, status flags and the result counter. Config writes are
  // only honoured while idle; a config write during a job flags an error.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      head_q      <= '0;
      dim_q       <= '0;
      length_q    <= '0;
      out_total_q <= '0;
      out_cnt_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (wr_fire && !busy) begin
        case (awaddr)
          ADDR_HEAD:      head_q      <= wdata[3:0];
          ADDR_DIM:       dim_q       <= wdata[6:0];
          ADDR_LENGTH:    length_q    <= wdata[5:0];
          ADDR_OUT_TOTAL: out_total_q <= wdata[15:0];
          default: ;
        endcase
      end
      if (clear_req || start_go) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        if (set_done)       done_q <= 1'b1;
        if (cfg_wr && busy) err_q  <= 1'b1;
      end
      if (start_go)  out_cnt_q <= '0;
      else if (take) out_cnt_q <= out_cnt_q + 16'd1;
    end
  end

  // Read data selection; unmapped addresses and CTRL read as zero.
  always_comb begin
    status              = '0;
    status[STAT_BUSY]   = busy;
    status[STAT_DONE]   = done_q;
    status[STAT_ERR]    = err_q;
    status[STAT_IRQ_EN] = IRQ_EN;
    rd_mux = '0;
    case (araddr)
      ADDR_HEAD:      rd_mux[3:0]  = head_q;
      ADDR_DIM:       rd_mux[6:0]  = dim_q;
      ADDR_LENGTH:    rd_mux[5:0]  = length_q;
      ADDR_OUT_TOTAL: rd_mux[15:0] = out_total_q;
      ADDR_STATUS:    rd_mux[3:0]  = status;
      default: ;
    endcase
  end

  // Read response: captured on the address handshake and held until taken.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (arready) begin
      rvalid <= 1'b1;
      rdata  <= rd_mux;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  // Unpacker: one input beat is buffered and handed to the core lane by lane.
  assign ss_tready    = (state_q == ST_RUN) && !din_full_q;
  assign core_din_vld = din_full_q;
  assign core_din_dat = din_lanes_q[lane_idx_q];

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      din_lanes_q <= '0;
      lane_idx_q  <= '0;
      din_full_q  <= 1'b0;
    end else if (clear_req || start_go) begin
      lane_idx_q <= '0;
      din_full_q <= 1'b0;
    end else if (ss_tvalid && ss_tready) begin
      din_lanes_q <= ss_tdata;
      lane_idx_q  <= '0;
      din_full_q  <= 1'b1;
    end else if (core_din_vld && core_din_rdy) begin
      if (lane_idx_q == IW'(LANES - 1)) begin
        lane_idx_q <= '0;
        din_full_q <= 1'b0;
      end else begin
        lane_idx_q <= lane_idx_q + IW'(1);
      end
    end
  end

  attn_lane_pack #(
    .ELEM_W (pELEM_WIDTH),
    .LANES  (LANES)
  ) u_pack (
    .clk      (axis_clk),
    .rst      (axis_rst),
    .flush    (pack_flush),
    .enable   (pack_en),
    .in_vld   (core_dout_vld),
    .in_dat   (core_dout_dat),
    .in_last  (take_last),
    .in_rdy   (core_dout_rdy),
    .out_vld  (sm_tvalid),
    .out_dat  (sm_tdata),
    .out_last (sm_tlast),
    .out_rdy  (sm_tready)
  );

`ifdef ATTN_WRAP_IRQ_EN
  logic irq_q;

  // One-cycle pulse coinciding with done being set.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) irq_q <= 1'b0;
    else          irq_q <= set_done;
  end

  assign low__pri_irq = irq_q;
`else
  assign low__pri_irq = 1'b0;
`endif

endmodule

// File: tb/tb_attn_stream_wrap.sv
// tb_attn_stream_wrap
// Directed bench for attn_stream_wrap with a one-element loopback core model.
// Honours ATTN_WRAP_IRQ_EN for the expected STATUS.irq_en bit and irq pulses.
module tb_attn_stream_wrap;

  localparam int DW = 32;
  localparam int EW = 16;
`ifdef ATTN_WRAP_IRQ_EN
  localparam logic [31:0] IRQ_BIT     = 32'h8;
  localparam int          IRQ_PER_JOB = 1;
`else
  localparam logic [31:0] IRQ_BIT     = 32'h0;
  localparam int          IRQ_PER_JOB = 0;
`endif

  logic          axis_clk = 1'b0;
  logic          axis_rst;
  logic          awvalid, awready, wvalid, wready;
  logic [11:0]   awaddr, araddr;
  logic [DW-1:0] wdata, rdata, ss_tdata, sm_tdata;
  logic          arvalid, arready, rvalid, rready;
  logic          ss_tvalid, ss_tready, sm_tvalid, sm_tready, sm_tlast;
  logic [16:0]   core_cfg;
  logic [EW-1:0] core_din_dat, core_dout_dat;
  logic          core_din_vld, core_din_rdy, core_dout_vld, core_dout_rdy;
  logic          low__pri_irq;

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;
  logic [31:0] beat_dat[$];
  logic        beat_last[$];
  logic [31:0] rd;

  logic          core_held = 1'b0;
  logic          core_flush = 1'b0;
  logic [EW-1:0] core_held_dat = '0;

  always #5 axis_clk = ~axis_clk;

  attn_stream_wrap #(.pDATA_WIDTH(DW), .pELEM_WIDTH(EW)) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .core_cfg(core_cfg),
    .core_din_dat(core_din_dat), .core_din_vld(core_din_vld), .core_din_rdy(core_din_rdy),
    .core_dout_dat(core_dout_dat), .core_dout_vld(core_dout_vld), .core_dout_rdy(core_dout_rdy),
    .low__pri_irq(low__pri_irq)
  );

  // Loopback core: holds one element and returns it unchanged.
  assign core_din_rdy  = !core_held;
  assign core_dout_vld = core_held;
  assign core_dout_dat = core_held_dat;

  always @(posedge axis_clk) begin
    if (axis_rst || core_flush) begin
      core_held <= 1'b0;
    end else begin
      if (core_dout_vld && core_dout_rdy) core_held <= 1'b0;
      if (core_din_vld && core_din_rdy) begin
        core_held     <= 1'b1;
        core_held_dat <= core_din_dat;
      end
    end
  end

  // Output beat and interrupt monitor.
  always @(posedge axis_clk) begin
    if (!axis_rst && sm_tvalid && sm_tready) begin
      beat_dat.push_back(sm_tdata);
      beat_last.push_back(sm_tlast);
    end
    if (!axis_rst && low__pri_irq) irq_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axiWrite(input logic [11:0] addr, input logic [31:0] data);
    @(negedge axis_clk);
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    checkOutput("awready", awready, 32'd1);
    @(negedge axis_clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axiRead(input logic [11:0] addr, output logic [31:0] data);
    int t;
    data = '0;
    @(negedge axis_clk);
    araddr = addr; arvalid = 1'b1;
    #1;
    t = 0;
    while (!arready && t < 50) begin @(negedge axis_clk); #1; t++; end
    if (!arready) checkOutput("arready timeout", 32'd0, 32'd1);
    @(negedge axis_clk);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 50) begin @(negedge axis_clk); t++; end
    if (!rvalid) checkOutput("rvalid timeout", 32'd0, 32'd1);
    data = rdata;
    rready = 1'b1;
    @(negedge axis_clk);
    rready = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] beat);
    int t;
    @(negedge axis_clk);
    ss_tdata = beat; ss_tvalid = 1'b1;
    #1;
    t = 0;
    while (!ss_tready && t < 200) begin @(negedge axis_clk); #1; t++; end
    if (!ss_tready) checkOutput("ss accept timeout", 32'd0, 32'd1);
    @(negedge axis_clk);
    ss_tvalid = 1'b0;
  endtask

  task automatic waitBeats(input int n);
    int t;
    t = 0;
    while (beat_dat.size() < n && t < 300) begin @(negedge axis_clk); t++; end
    checkOutput("beat count", beat_dat.size(), n);
  endtask

  task automatic waitSmValid();
    int t;
    t = 0;
    while (!sm_tvalid && t < 200) begin @(negedge axis_clk); t++; end
    checkOutput("sm_tvalid rise", sm_tvalid, 32'd1);
  endtask

  task automatic newJob(input logic rdy);
    @(negedge axis_clk);
    core_flush = 1'b1;
    sm_tready = rdy;
    @(negedge axis_clk);
    core_flush = 1'b0;
    beat_dat.delete();
    beat_last.delete();
  endtask

  task automatic checkBeats(input logic [31:0] exp_dat[3], input logic exp_last[3]);
    for (int i = 0; i < 3; i++) begin
      if (i < beat_dat.size()) begin
        checkOutput($sformatf("beat%0d data", i), beat_dat[i], exp_dat[i]);
        checkOutput($sformatf("beat%0d tlast", i), beat_last[i], exp_last[i]);
      end
    end
  endtask

  initial begin
    logic [31:0] exp_dat[3];
    logic        exp_last[3];

    axis_rst = 1'b1;
    awvalid = 0; wvalid = 0; awaddr = '0; wdata = '0;
    arvalid = 0; araddr = '0; rready = 0;
    ss_tvalid = 0; ss_tdata = '0; sm_tready = 0;

    repeat (2) @(negedge axis_clk);
    checkOutput("rst awready", awready, 0);
    checkOutput("rst wready", wready, 0);
    checkOutput("rst arready", arready, 0);
    checkOutput("rst rvalid", rvalid, 0);
    checkOutput("rst ss_tready", ss_tready, 0);
    checkOutput("rst sm_tvalid", sm_tvalid, 0);
    checkOutput("rst sm_tlast", sm_tlast, 0);
    checkOutput("rst sm_tdata", sm_tdata, 0);
    checkOutput("rst rdata", rdata, 0);
    checkOutput("rst core_din_vld", core_din_vld, 0);
    checkOutput("rst core_din_dat", {16'h0, core_din_dat}, 0);
    checkOutput("rst core_dout_rdy", core_dout_rdy, 0);
    checkOutput("rst irq", low__pri_irq, 0);
    checkOutput("rst core_cfg", {15'h0, core_cfg}, 0);
    axis_rst = 1'b0;

    $display("[TB] register access");
    axiRead(12'h014, rd); checkOutput("status after reset", rd, IRQ_BIT);
    axiWrite(12'h004, 32'd2);
    axiWrite(12'h008, 32'd64);
    axiWrite(12'h00C, 32'd8);
    axiRead(12'h004, rd); checkOutput("head readback", rd, 32'd2);
    axiRead(12'h008, rd); checkOutput("dim readback", rd, 32'd64);
    axiRead(12'h00C, rd); checkOutput("length readback", rd, 32'd8);
    checkOutput("core_cfg", {15'h0, core_cfg}, {15'h0, 4'd2, 7'd64, 6'd8});
    axiRead(12'h000, rd); checkOutput("ctrl reads 0", rd, 0);
    axiWrite(12'h018, 32'hFFFF_FFFF);
    axiRead(12'h018, rd); checkOutput("unmapped reads 0", rd, 0);

    $display("[TB] job with partial final beat");
    newJob(1'b1);
    axiWrite(12'h010, 32'd5);
    axiWrite(12'h000, 32'd1);
    axiRead(12'h014, rd); checkOutput("status busy", rd, 32'h1 | IRQ_BIT);
    applyStimulus(32'h0002_0001);
    applyStimulus(32'h0004_0003);
    applyStimulus(32'h0006_0005);
    waitBeats(3);
    repeat (3) @(negedge axis_clk);
    exp_dat  = '{32'h0002_0001, 32'h0004_0003, 32'h0000_0005};
    exp_last = '{1'b0, 1'b0, 1'b1};
    checkBeats(exp_dat, exp_last);
    axiRead(12'h014, rd); checkOutput("status done", rd, 32'h2 | IRQ_BIT);
    checkOutput("irq pulses job1", irq_cnt, IRQ_PER_JOB);

    $display("[TB] output backpressure");
    newJob(1'b0);
    axiWrite(12'h010, 32'd6);
    axiWrite(12'h000, 32'd1);
    applyStimulus(32'h0011_0010);
    waitSmValid();
    applyStimulus(32'h0013_0012);
    repeat (4) @(negedge axis_clk);
    for (int i = 0; i < 20; i++) begin
      checkOutput("stall sm_tdata", sm_tdata, 32'h0011_0010);
      checkOutput("stall core_dout_rdy", core_dout_rdy, 0);
      @(negedge axis_clk);
    end
    sm_tready = 1'b1;
    applyStimulus(32'h0015_0014);
    waitBeats(3);
    repeat (3) @(negedge axis_clk);
    exp_dat  = '{32'h0011_0010, 32'h0013_0012, 32'h0015_0014};
    exp_last = '{1'b0, 1'b0, 1'b1};
    checkBeats(exp_dat, exp_last);
    axiRead(12'h014, rd); checkOutput("status done job2", rd, 32'h2 | IRQ_BIT);
    checkOutput("irq pulses job2", irq_cnt, 2 * IRQ_PER_JOB);

    $display("[TB] busy write and clear");
    newJob(1'b0);
    axiWrite(12'h010, 32'd4);
    axiWrite(12'h000, 32'd1);
    axiWrite(12'h008, 32'd3);
    axiRead(12'h008, rd); checkOutput("dim kept while busy", rd, 32'd64);
    axiRead(12'h014, rd); checkOutput("status err", rd, 32'h5 | IRQ_BIT);
    applyStimulus(32'h0021_0020);
    waitSmValid();
    axiWrite(12'h000, 32'd2);
    checkOutput("clear sm_tvalid", sm_tvalid, 0);
    checkOutput("clear core_din_vld", core_din_vld, 0);
    checkOutput("clear ss_tready", ss_tready, 0);
    axiRead(12'h014, rd); checkOutput("status after clear", rd, IRQ_BIT);
    checkOutput("cfg kept after clear", {15'h0, core_cfg}, {15'h0, 4'd2, 7'd64, 6'd8});
    axiRead(12'h010, rd); checkOutput("out_total kept", rd, 32'd4);
    checkOutput("no irq on clear", irq_cnt, 2 * IRQ_PER_JOB);

    $display("[TB] zero-length job");
    newJob(1'b1);
    axiWrite(12'h010, 32'd0);
    axiWrite(12'h000, 32'd1);
    repeat (2) @(negedge axis_clk);
    axiRead(12'h014, rd); checkOutput("status zero job", rd, 32'h2 | IRQ_BIT);
    checkOutput("zero job no beats", beat_dat.size(), 0);
    checkOutput("irq pulses zero job", irq_cnt, 3 * IRQ_PER_JOB);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/attn_stream_wrap.md
ATTN_STREAM_WRAP -- requirements
Module: attn_stream_wrap
Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 32, meaning AXI-lite/stream word width.
REQ-002 SHALL have parameter pELEM_WIDTH, default 16, meaning core element width; LANES = pDATA_WIDTH/pELEM_WIDTH (integer, >=1).
REQ-003 SHALL have port axis_clk  in  1  sole clock; one clock domain.
REQ-004 SHALL have port axis_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port awvalid  in  1  write-address valid.
REQ-006 SHALL have port awready  out  1  write-address ready.
REQ-007 SHALL have port awaddr  in  12  write byte address.
REQ-008 SHALL have port wvalid  in  1  write-data valid.
REQ-009 SHALL have port wready  out  1  write-data ready.
REQ-010 SHALL have port wdata  in  pDATA_WIDTH  write data.
REQ-011 SHALL have port arvalid  in  1  read-address valid.
REQ-012 SHALL have port arready  out  1  read-address ready.
REQ-013 SHALL have port araddr  in  12  read byte address.
REQ-014 SHALL have port rvalid  out  1  read-data valid.
REQ-015 SHALL have port rready  in  1  read-data ready.
REQ-016 SHALL have port rdata  out  pDATA_WIDTH  read data.
REQ-017 SHALL have port ss_tvalid  in  1  input stream valid.
REQ-018 SHALL have port ss_tready  out  1  input stream ready.
REQ-019 SHALL have port ss_tdata  in  pDATA_WIDTH  LANES packed elements, lane 0 in LSBs.
REQ-020 SHALL have port sm_tvalid  out  1  output stream valid.
REQ-021 SHALL have port sm_tready  in  1  output stream ready.
REQ-022 SHALL have port sm_tdata  out  pDATA_WIDTH  LANES packed result elements.
REQ-023 SHALL have port sm_tlast  out  1  final beat of a job.
REQ-024 SHALL have port core_cfg  out  17  {head[3:0], dim[6:0], length[5:0]}.
REQ-025 SHALL have port core_din_dat  out  pELEM_WIDTH  element to core.
REQ-026 SHALL have port core_din_vld  out  1  element valid.
REQ-027 SHALL have port core_din_rdy  in  1  core accepts element.
REQ-028 SHALL have port core_dout_dat  in  pELEM_WIDTH  core result element.
REQ-029 SHALL have port core_dout_vld  in  1  result valid.
REQ-030 SHALL have port core_dout_rdy  out  1  wrapper accepts result.
REQ-031 SHALL have port low__pri_irq  out  1  job-done interrupt pulse.
Function
REQ-032 Registers SHALL be: 0x00 CTRL (write bit0 start, bit1 clear; self-clearing, reads 0); 0x04 HEAD[3:0]; 0x08 DIM[6:0]; 0x0C LENGTH[5:0]; 0x10 OUT_TOTAL[15:0] elements; 0x14 STATUS read-only {irq_en[3], err[2], done[1], busy[0]}; other addresses write-ignored, read 0.
REQ-033 Write SHALL complete only when awvalid&&wvalid: awready=wready=1 for exactly that cycle, register updated next edge; HEAD/DIM/LENGTH/OUT_TOTAL writes while busy SHALL be dropped and set err.
REQ-034 Read SHALL assert arready one cycle on arvalid when no response pending; rvalid rises next cycle, rdata held stable until rvalid&&rready; reads and writes in the same cycle both proceed.
REQ-035 FSM SHALL be IDLE->RUN on start (clears done/err, zeros counters), RUN->DRAIN when OUT_TOTAL elements have been taken from the core, DRAIN->IDLE when final sm beat handshakes (sets done); start while busy ignored.
REQ-036 Unpacker SHALL accept one ss beat only in RUN with lane buffer empty, then present lanes 0..LANES-1 in order on core_din, one per core_din_vld&&core_din_rdy; ss_tready=0 outside RUN.
REQ-037 Packer SHALL collect LANES results (core_dout_rdy=1 while packer not full and in RUN), then hold sm_tvalid/sm_tdata until sm_tready; a partial final beat SHALL be zero-padded in unfilled lanes and carry sm_tlast=1; OUT_TOTAL=0 SHALL go RUN->IDLE in one cycle with done set and no sm beat.
REQ-038 CTRL.clear SHALL in any state return to IDLE within one cycle, discard buffered lanes, drop sm_tvalid/core_din_vld, clear done/err, and keep HEAD/DIM/LENGTH/OUT_TOTAL.
Reset
REQ-039 On axis_rst SHALL force IDLE, all registers 0, and every output 0 (awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast, core_din_vld, core_dout_rdy, low__pri_irq, data buses).
Configuration
REQ-040 With ATTN_WRAP_IRQ_EN defined, low__pri_irq SHALL pulse high one cycle on the done-setting edge and STATUS.irq_en reads 1; without it low__pri_irq is tied 0 and irq_en reads 0.
Structure
REQ-041 Register offsets, STATUS bit positions and FSM state enum SHALL live in shared package attn_wrap_pkg; the lane packer SHALL be sub-module attn_lane_pack; the unpacker stays inline.
Verification
REQ-042 Write HEAD=2, DIM=64, LENGTH=8, read back each -> rdata 2, 64, 8; core_cfg = {4'd2,7'd64,6'd8}.
REQ-043 OUT_TOTAL=5, start, feed beats 0x0002_0001, 0x0004_0003, 0x0006_0005, loopback core -> sm beats 0x0002_0001, 0x0004_0003, 0x0000_0005 with tlast on third; STATUS=0x2 (0xA with macro) and one irq pulse.
REQ-044 Hold sm_tready=0 for 20 cycles mid-job -> sm_tdata stable, core_dout_rdy falls once packer full, no element lost.
REQ-045 Write DIM=3 while busy -> DIM unchanged, STATUS.err=1; CTRL.clear mid-job -> IDLE next cycle, sm_tvalid=0, busy=0.
